// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single data-memory port.
// Port 0 is the MEM stage, port 1 the debug/loader port.
module dmem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        p0_req_i,
  input  logic [1:0]  p0_read_i,
  input  logic [1:0]  p0_write_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  output logic [31:0] p0_rdata_o,
  output logic        p0_done_o,
  output logic        p0_stall_o,
  input  logic        p1_req_i,
  input  logic [1:0]  p1_read_i,
  input  logic [1:0]  p1_write_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  output logic [31:0] p1_rdata_o,
  output logic        p1_done_o,
  output logic [1:0]  mem_read_o,
  output logic [1:0]  mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);
  localparam logic [3:0] SMAX   = 4'(STARVE_MAX);

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic [1:0]  mem_read_q, mem_read_d;
  logic [1:0]  mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
  logic        p0_done_q, p0_done_d;
  logic        p1_done_q, p1_done_d;

  logic        grant1;
  logic [1:0]  sel_read;
  logic [1:0]  sel_write;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_done_d   = 1'b0;
    p1_done_d   = 1'b0;
    grant1      = p1_req_i & (~p0_req_i | (starve_q == SMAX));
    sel_read    = grant1 ? p1_read_i : p0_read_i;
    sel_write   = grant1 ? p1_write_i : p0_write_i;
    unique case (state_q)
      S_IDLE: begin
        if (!p1_req_i) starve_d = 4'd0;
        if (p0_req_i || p1_req_i) begin
          owner_d     = grant1;
          // a write wins over a simultaneous read code
          mem_read_d  = (sel_write != 2'd0) ? 2'd0 : sel_read;
          mem_write_d = sel_write;
          mem_addr_d  = grant1 ? p1_addr_i : p0_addr_i;
          mem_wdata_d = grant1 ? p1_wdata_i : p0_wdata_i;
          cnt_d       = LAT_M1;
          state_d     = S_BUSY;
          if (grant1) begin
            starve_d = 4'd0;
          end else if (p1_req_i && starve_q != SMAX) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 2'd0) begin
          state_d     = S_RESP;
          mem_read_d  = 2'd0;
          mem_write_d = 2'd0;
          if (mem_read_q != 2'd0) begin
            if (owner_q) p1_rdata_d = mem_rdata_i;
            else         p0_rdata_d = mem_rdata_i;
          end
          p0_done_d = ~owner_q;
          p1_done_d = owner_q;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= 2'd0;
      starve_q    <= 4'd0;
      mem_read_q  <= 2'd0;
      mem_write_q <= 2'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      p0_rdata_q  <= 32'd0;
      p1_rdata_q  <= 32'd0;
      p0_done_q   <= 1'b0;
      p1_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_done_q   <= p0_done_d;
      p1_done_q   <= p1_done_d;
    end
  end

  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign p0_rdata_o  = p0_rdata_q;
  assign p1_rdata_o  = p1_rdata_q;
  assign p0_done_o   = p0_done_q;
  assign p1_done_o   = p1_done_q;
  assign p0_stall_o  = p0_req_i & ~p0_done_q;

endmodule
